riscv_hazard_ctrl_mc: RTL and testbench

Parametrised successor to the pipeline hazard unit of the 5-stage RISC-V core (F/D/E/M/W).
- Keeps the existing functions: forwarding, load-use stall and branch/jump flush.
- Adds a sequential handshake controller for instruction and data memories that may take more than one cycle. It freezes the whole pipeline while memory is not ready.
- Adds a wait-timeout watchdog and stall-cycle accounting.
- Sits beside the datapath and controller inside the core top.

---
 rtl/riscv_hazard_ctrl_mc.sv | 253 +++++++++++++++++++++++++
 tb/tb_riscv_hazard_ctrl_mc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_hazard_ctrl_mc.sv
// ---------------------------------------------------------------------------
// riscv_hazard_ctrl_mc
//
// Hazard unit for the 5-stage (F/D/E/M/W) RISC-V core. It provides:
//   - E-stage operand forwarding (from M or W)
//   - load-use stall, or a full RAW stall when forwarding is disabled
//   - branch/jump flush
//   - a pipeline freeze while instruction or data memory is not ready
//   - a data-memory wait watchdog (sticky error)
//   - an optional stall-cycle counter
//
// Optional feature macro: RISCV_HAZ_PERF_CNT_EN
//   defined     -> stall_cycles counts cycles with StallF=1 (saturating)
//   not defined -> stall_cycles is tied to 0 and no counter flops exist
//
// Parameters:
//   REG_AW      register-address width (5 = RV32I, 4 = RV32E)
//   FWD_EN      1 = forwarding enabled, 0 = stall on every RAW hazard
//   MEM_TIMEOUT data-memory wait cycles tolerated before the error (1..65535)
//   CNT_W       performance counter width
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   Rs1D/Rs2D, Rs1E/Rs2E       source registers in D and E
//   RdE/RdM/RdW, RegWrite*     destinations and write enables in E/M/W
//   ResultSrcE0                E-stage instruction is a load
//   PCSrcE                     branch/jump taken in E
//   MemReqM, dmem_ready        data-memory request / completion
//   imem_ready                 instruction memory delivers InstrF
//   ForwardAE/BE               00 = RF, 10 = from M, 01 = from W
//   StallF/D/E/M               hold stage register
//   FlushD/E/W                 insert bubble into stage register
//   mem_timeout                sticky watchdog error
//   stall_cycles               cycles with StallF=1 (optional feature)
//   dbg_state                  FSM state (0 = RUN, 1 = DWAIT, 2 = ERR)
//
// Memory handshake: an access issued by the M stage (MemReqM=1) is complete
// in the cycle dmem_ready=1; every cycle with MemReqM=1 and dmem_ready=0 is
// a wait cycle and freezes F/D/E/M. imem_ready=0 means InstrF is not valid
// this cycle; only F is held and a bubble enters D.
// ---------------------------------------------------------------------------
module riscv_hazard_ctrl_mc #(
    parameter int REG_AW      = 5,
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              dmem_ready,
    input  logic              imem_ready,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [1:0]        dbg_state
);

    localparam int                 WCNT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic dmem_stall;
    logic freeze;
    logic raw_stall;

    // Register 0 never carries a hazard.
    function automatic logic hit(input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd,
                                 input logic              we);
        return we && (rd != '0) && (rs == rd);
    endfunction

    assign dmem_stall = MemReqM & ~dmem_ready;
    assign freeze     = dmem_stall | (state_q == ST_ERR);
    assign dbg_state  = state_q;

    // -----------------------------------------------------------------------
    // Wait-tracking FSM. wait_cnt_q holds the number of consecutive wait
    // cycles already seen; it reaches MEM_TIMEOUT after MEM_TIMEOUT waits.
    // One further wait cycle moves to ERR, while dmem_ready in that cycle
    // still completes the access normally.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (dmem_stall) begin
                    state_d    = ST_DWAIT;
                    wait_cnt_d = WCNT_W'(1);
                end
            end
            ST_DWAIT: begin
                if (!dmem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q >= WAIT_MAX) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // D-stage stall condition: load-use with forwarding, any RAW without it.
    // -----------------------------------------------------------------------
    always_comb begin
        raw_stall = 1'b0;
        if (FWD_EN != 0) begin
            raw_stall = ResultSrcE0 &
                        (hit(Rs1D, RdE, RegWriteE) | hit(Rs2D, RdE, RegWriteE));
        end else begin
            raw_stall = hit(Rs1D, RdE, RegWriteE) | hit(Rs2D, RdE, RegWriteE) |
                        hit(Rs1D, RdM, RegWriteM) | hit(Rs2D, RdM, RegWriteM) |
                        hit(Rs1D, RdW, RegWriteW) | hit(Rs2D, RdW, RegWriteW);
        end
    end

    // -----------------------------------------------------------------------
    // Output decode. While reset is high every output is held low so nothing
    // pulses after the reset edge, even if memory is still busy.
    // -----------------------------------------------------------------------
    always_comb begin
        ForwardAE   = 2'b00;
        ForwardBE   = 2'b00;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        mem_timeout = (state_q == ST_ERR);

        if (FWD_EN != 0) begin
            if (hit(Rs1E, RdM, RegWriteM))      ForwardAE = 2'b10;
            else if (hit(Rs1E, RdW, RegWriteW)) ForwardAE = 2'b01;
            if (hit(Rs2E, RdM, RegWriteM))      ForwardBE = 2'b10;
            else if (hit(Rs2E, RdW, RegWriteW)) ForwardBE = 2'b01;
        end

        if (freeze) begin
            // A taken branch in E stays in the frozen E register and is
            // acted on once the freeze lifts.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (raw_stall) begin
            if (PCSrcE) begin
                // The consumer in D is on the wrong path: squash, no stall.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (!imem_ready) begin
            StallF = 1'b1;
            FlushD = 1'b1;
        end

        if (reset) begin
            ForwardAE   = 2'b00;
            ForwardBE   = 2'b00;
            StallF      = 1'b0;
            StallD      = 1'b0;
            StallE      = 1'b0;
            StallM      = 1'b0;
            FlushD      = 1'b0;
            FlushE      = 1'b0;
            FlushW      = 1'b0;
            mem_timeout = 1'b0;
        end
    end

`ifdef RISCV_HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallF && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_riscv_hazard_ctrl_mc.sv
// ---------------------------------------------------------------------------
// Testbench for riscv_hazard_ctrl_mc (MEM_TIMEOUT = 4, FWD_EN = 1).
// Directed vectors are applied 1 ns after each rising edge; the expected
// output word is pushed into exp_q at the same time. A monitor on the
// falling edge pops and compares one entry per cycle.
// ---------------------------------------------------------------------------
module tb_riscv_hazard_ctrl_mc;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
    localparam int W      = 14 + CNT_W;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DWAIT = 2'd1;
    localparam logic [1:0] S_ERR   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              ResultSrcE0, PCSrcE, MemReqM, dmem_ready, imem_ready;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, StallE, StallM;
    logic              FlushD, FlushE, FlushW, mem_timeout;
    logic [CNT_W-1:0]  stall_cycles;
    logic [1:0]        dbg_state;

    riscv_hazard_ctrl_mc #(
        .REG_AW(REG_AW), .FWD_EN(1), .MEM_TIMEOUT(4), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_vec  = 0;
    int           n_fail = 0;
    int           exp_sc = 0;

    logic [W-1:0] act_v, exp_v;
    string        nm;

    assign act_v = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                    FlushD, FlushE, FlushW, mem_timeout, dbg_state, stall_cycles};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            n_vec++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b to=%b st=%0d sc=%0d, expected fa=%b fb=%b stall=%b flush=%b to=%b st=%0d sc=%0d",
                         nm, act_v[W-1-:2], act_v[W-3-:2], act_v[W-5-:4], act_v[W-9-:3],
                         act_v[W-12], act_v[W-13-:2], act_v[CNT_W-1:0],
                         exp_v[W-1-:2], exp_v[W-3-:2], exp_v[W-5-:4], exp_v[W-9-:3],
                         exp_v[W-12], exp_v[W-13-:2], exp_v[CNT_W-1:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE0 = 1'b0; PCSrcE = 1'b0; MemReqM = 1'b0;
        dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    // stall = {F,D,E,M}, flush = {D,E,W}
    task automatic check(input string nm_i, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [3:0] stall, input logic [2:0] flush,
                         input logic to, input logic [1:0] st);
        logic [CNT_W-1:0] sc;
`ifdef RISCV_HAZ_PERF_CNT_EN
        sc = CNT_W'(exp_sc);
`else
        sc = '0;
`endif
        exp_q.push_back({fa, fb, stall, flush, to, st, sc});
        name_q.push_back(nm_i);
        if (stall[3]) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        exp_sc = 0;
        check("reset_hold", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);
        reset = 1'b0;

        idle(); check("idle", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        // lw x5 in E, consumer reads x5 in D
        idle(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 5; Rs1D = 5;
        check("load_use", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, S_RUN);
        // consumer now in E, load in W
        idle(); Rs1E = 5; RdW = 5; RegWriteW = 1;
        check("fwd_w_a", 2'b01, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        idle(); Rs2E = 7; RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1;
        check("fwd_m_prio_b", 2'b00, 2'b10, 4'b0000, 3'b000, 1'b0, S_RUN);
        idle(); Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1; RegWriteW = 1;
        check("fwd_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);
        idle(); Rs1E = 3; RdM = 3; RegWriteM = 1; Rs2E = 4; RdW = 4; RegWriteW = 1;
        check("fwd_both", 2'b10, 2'b01, 4'b0000, 3'b000, 1'b0, S_RUN);
        idle(); Rs1E = 3; RdM = 3; RdW = 3;
        check("fwd_no_we", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        // 3-cycle data-memory wait with a pending branch in E
        for (int i = 0; i < 3; i++) begin
            idle(); MemReqM = 1; dmem_ready = 0; PCSrcE = 1;
            check("dwait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, (i == 0) ? S_RUN : S_DWAIT);
        end
        idle(); MemReqM = 1; dmem_ready = 1; PCSrcE = 1;
        check("dwait_release", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, S_DWAIT);
        idle(); check("after_release", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        // instruction memory not ready
        for (int i = 0; i < 2; i++) begin
            idle(); imem_ready = 0;
            check("imem_wait", 2'b00, 2'b00, 4'b1000, 3'b100, 1'b0, S_RUN);
        end
        idle(); check("imem_done", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        // load-use vs branch, x0 load, ALU producer
        idle(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 6; Rs2D = 6; PCSrcE = 1;
        check("lu_branch", 2'b00, 2'b00, 4'b0000, 3'b110, 1'b0, S_RUN);
        idle(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 0; Rs1D = 0;
        check("lu_x0", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);
        idle(); RegWriteE = 1; RdE = 9; Rs1D = 9;
        check("alu_no_stall", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);
        idle(); ResultSrcE0 = 1; RegWriteE = 1; RdE = 8; Rs2D = 8; imem_ready = 0;
        check("lu_over_imem", 2'b00, 2'b00, 4'b1100, 3'b010, 1'b0, S_RUN);

        // ready rises exactly when the wait counter sits at MEM_TIMEOUT
        for (int i = 0; i < 4; i++) begin
            idle(); MemReqM = 1; dmem_ready = 0;
            check("to_edge_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, (i == 0) ? S_RUN : S_DWAIT);
        end
        idle(); MemReqM = 1; dmem_ready = 1;
        check("to_edge_done", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_DWAIT);
        idle(); check("to_edge_run", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        // watchdog: one wait beyond MEM_TIMEOUT enters ERR
        for (int i = 0; i < 5; i++) begin
            idle(); MemReqM = 1; dmem_ready = 0;
            check("to_wait", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b0, (i == 0) ? S_RUN : S_DWAIT);
        end
        idle(); MemReqM = 1; dmem_ready = 0;
        check("err_entry", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, S_ERR);
        idle(); PCSrcE = 1;
        check("err_sticky", 2'b00, 2'b00, 4'b1111, 3'b001, 1'b1, S_ERR);

        // asynchronous reset in ERR with memory still busy
        idle(); MemReqM = 1; dmem_ready = 0; reset = 1'b1;
        exp_sc = 0;
        check("reset_in_err", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);
        reset = 1'b0;
        idle(); check("post_reset", 2'b00, 2'b00, 4'b0000, 3'b000, 1'b0, S_RUN);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule
